// File: rtl/timer_field_counter_if.sv
// -----------------------------------------------------------------------------
// timer_field_counter_if
// Control/status bundle for one timer field (seconds, minutes, hours ...).
//   enable      : block active when high, frozen when low
//   mode        : 00 HOLD, 01 SET, 10 DOWN, 11 UP
//   inc / dec   : single-cycle +1 / -1 strobes, honoured only in SET
//   tick_in     : count strobe from the lower field or the timebase
//   load        : load load_value in SET
//   load_value  : preset value (saturated to MODULO-1 by the field)
//   value       : current field value
//   tc_out      : one-cycle terminal-count / borrow strobe to the next field
//   finish      : sticky countdown-expired flag
//   state       : IDLE=0, SET=1, DOWN=2, UP=3, DONE=4
// master drives the controls (display/controller side), slave is the field.
// -----------------------------------------------------------------------------
interface timer_field_counter_if #(
    parameter int WIDTH = 6
);
    logic             enable;
    logic [1:0]       mode;
    logic             inc;
    logic             dec;
    logic             tick_in;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] value;
    logic             tc_out;
    logic             finish;
    logic [2:0]       state;

    modport master (
        output enable, mode, inc, dec, tick_in, load, load_value,
        input  value, tc_out, finish, state
    );

    modport slave (
        input  enable, mode, inc, dec, tick_in, load, load_value,
        output value, tc_out, finish, state
    );
endinterface

// File: rtl/timer_field_counter.sv
// -----------------------------------------------------------------------------
// timer_field_counter
// Parametrised modulo timer field with hold / set / count-down / count-up
// modes. Fields cascade through tc_out -> tick_in of the next field.
//   clk_1Hz : clock, all state changes on its rising edge
//   reset   : synchronous, active-high reset
//   bus     : timer_field_counter_if.slave (controls in, value/status out)
// Parameters:
//   WIDTH  : width of value / load_value
//   MODULO : field wraps at MODULO-1 (2 .. 2**WIDTH)
//   INIT   : reset value of value (< MODULO)
// The action taken on each edge is selected by the registered state, so a
// mode change takes effect one cycle later and strobes in the mode-change
// cycle are handled by the old state. All outputs come straight from flops.
// -----------------------------------------------------------------------------
module timer_field_counter #(
    parameter int WIDTH  = 6,
    parameter int MODULO = 60,
    parameter int INIT   = 0
) (
    input  logic                  clk_1Hz,
    input  logic                  reset,
    timer_field_counter_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SET  = 3'd1,
        ST_DOWN = 3'd2,
        ST_UP   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] value_r;
    logic [WIDTH-1:0] value_nxt_s;
    logic             tc_r;
    logic             tc_nxt_s;
    logic             finish_r;
    logic             finish_nxt_s;

    // Modulo increment: MODULO-1 wraps to 0.
    function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v);
        if (v == MAX_VAL) begin
            wrap_inc = ZERO_VAL;
        end else begin
            wrap_inc = v + ONE_VAL;
        end
    endfunction

    // Modulo decrement: 0 wraps to MODULO-1.
    function automatic logic [WIDTH-1:0] wrap_dec(input logic [WIDTH-1:0] v);
        if (v == ZERO_VAL) begin
            wrap_dec = MAX_VAL;
        end else begin
            wrap_dec = v - ONE_VAL;
        end
    endfunction

    // Preset with saturation; extra MSB keeps the compare valid at MODULO=2**WIDTH.
    function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v);
        if ({1'b0, v} > {1'b0, MAX_VAL}) begin
            sat_load = MAX_VAL;
        end else begin
            sat_load = v;
        end
    endfunction

    // State, value and status registers with synchronous reset.
    always_ff @(posedge clk_1Hz) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            value_r  <= INIT_VAL;
            tc_r     <= 1'b0;
            finish_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            value_r  <= value_nxt_s;
            tc_r     <= tc_nxt_s;
            finish_r <= finish_nxt_s;
        end
    end

    // Next-state selection: countdown expiry beats mode, DONE is sticky under mode 10.
    always_comb begin
        state_nxt_s = state_r;
        if (bus.enable) begin
            if ((state_r == ST_DOWN) && bus.tick_in && (value_r == ZERO_VAL)) begin
                state_nxt_s = ST_DONE;
            end else begin
                case (bus.mode)
                    2'b00:   state_nxt_s = ST_IDLE;
                    2'b01:   state_nxt_s = ST_SET;
                    2'b10:   state_nxt_s = (state_r == ST_DONE) ? ST_DONE : ST_DOWN;
                    2'b11:   state_nxt_s = ST_UP;
                    default: state_nxt_s = ST_IDLE;
                endcase
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Per-state datapath action; tc_out defaults low so it is a single-cycle strobe.
    always_comb begin
        value_nxt_s  = value_r;
        tc_nxt_s     = 1'b0;
        finish_nxt_s = finish_r;
        if (bus.enable) begin
            // finish tracks DONE: set on entry, held while there, cleared on exit.
            finish_nxt_s = (state_nxt_s == ST_DONE);
            case (state_r)
                ST_SET: begin
                    if (bus.load) begin
                        value_nxt_s = sat_load(bus.load_value);
                    end else if (bus.inc && !bus.dec) begin
                        value_nxt_s = wrap_inc(value_r);
                    end else if (bus.dec && !bus.inc) begin
                        value_nxt_s = wrap_dec(value_r);
                    end else begin
                        value_nxt_s = value_r;
                    end
                end
                ST_DOWN: begin
                    if (bus.tick_in) begin
                        if (value_r != ZERO_VAL) begin
                            value_nxt_s = value_r - ONE_VAL;
                        end else begin
                            tc_nxt_s = 1'b1;
                        end
                    end else begin
                        value_nxt_s = value_r;
                    end
                end
                ST_UP: begin
                    if (bus.tick_in) begin
                        value_nxt_s = wrap_inc(value_r);
                        tc_nxt_s    = (value_r == MAX_VAL);
                    end else begin
                        value_nxt_s = value_r;
                    end
                end
                default: begin
                    value_nxt_s = value_r;
                end
            endcase
        end else begin
            value_nxt_s  = value_r;
            finish_nxt_s = finish_r;
        end
    end

    assign bus.value  = value_r;
    assign bus.tc_out = tc_r;
    assign bus.finish = finish_r;
    assign bus.state  = state_r;

endmodule

// File: tb/tb_timer_field_counter.sv
// -----------------------------------------------------------------------------
// tb_timer_field_counter
// Directed bench for timer_field_counter (WIDTH=6, MODULO=60, INIT=0).
// Inputs change #1 after a rising edge; outputs are sampled #1 after the
// following rising edge.
// -----------------------------------------------------------------------------
module tb_timer_field_counter;

    logic clk_1Hz;
    logic reset;
    int   checks;
    int   failures;
    int   exp_v;

    timer_field_counter_if #(.WIDTH(6)) bus_if ();

    timer_field_counter #(
        .WIDTH  (6),
        .MODULO (60),
        .INIT   (0)
    ) dut (
        .clk_1Hz (clk_1Hz),
        .reset   (reset),
        .bus     (bus_if.slave)
    );

    initial clk_1Hz = 1'b0;
    always #5 clk_1Hz = ~clk_1Hz;

    task automatic step();
        @(posedge clk_1Hz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int v, input int tc, input int fin, input int st);
        chk({tag, ".value"},  32'(bus_if.value),  32'(v));
        chk({tag, ".tc_out"}, 32'(bus_if.tc_out), 32'(tc));
        chk({tag, ".finish"}, 32'(bus_if.finish), 32'(fin));
        chk({tag, ".state"},  32'(bus_if.state),  32'(st));
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        bus_if.enable     = 1'b0;
        bus_if.mode       = 2'b00;
        bus_if.inc        = 1'b0;
        bus_if.dec        = 1'b0;
        bus_if.tick_in    = 1'b0;
        bus_if.load       = 1'b0;
        bus_if.load_value = 6'd0;

        // Reset state
        step();
        chk_all("reset", 0, 0, 0, 0);
        reset = 1'b0;

        // Enter SET
        bus_if.enable = 1'b1;
        bus_if.mode   = 2'b01;
        step();
        chk_all("enter_set", 0, 0, 0, 1);

        // 61 inc strobes: 1..59, 0, 1 and never a tc_out
        bus_if.inc = 1'b1;
        for (int i = 1; i <= 61; i++) begin
            step();
            exp_v = i % 60;
            chk("inc_walk.value", 32'(bus_if.value), 32'(exp_v));
            chk("inc_walk.tc_out", 32'(bus_if.tc_out), 32'd0);
        end
        bus_if.inc = 1'b0;

        // Saturating load
        bus_if.load       = 1'b1;
        bus_if.load_value = 6'd63;
        step();
        chk_all("load_sat", 59, 0, 0, 1);
        bus_if.load = 1'b0;

        // 60 dec strobes from 59 wrap through 0 back to 59
        bus_if.dec = 1'b1;
        exp_v = 59;
        for (int i = 1; i <= 60; i++) begin
            step();
            exp_v = (exp_v == 0) ? 59 : exp_v - 1;
            chk("dec_walk.value", 32'(bus_if.value), 32'(exp_v));
            chk("dec_walk.tc_out", 32'(bus_if.tc_out), 32'd0);
        end
        chk("dec_end", 32'(bus_if.value), 32'd59);

        // inc and dec together: no change
        bus_if.inc = 1'b1;
        step();
        chk_all("inc_dec_both", 59, 0, 0, 1);
        bus_if.inc = 1'b0;
        bus_if.dec = 1'b0;

        // Load 2 and start a countdown
        bus_if.load       = 1'b1;
        bus_if.load_value = 6'd2;
        step();
        chk_all("load_2", 2, 0, 0, 1);
        bus_if.load = 1'b0;
        bus_if.mode = 2'b10;
        step();
        chk_all("enter_down", 2, 0, 0, 2);

        bus_if.tick_in = 1'b1;
        step();
        chk_all("down_t1", 1, 0, 0, 2);
        step();
        chk_all("down_t2", 0, 0, 0, 2);
        step();
        chk_all("down_expire", 0, 1, 1, 4);
        step();
        chk_all("done_tick", 0, 0, 1, 4);
        bus_if.inc  = 1'b1;
        bus_if.load = 1'b1;
        bus_if.load_value = 6'd9;
        step();
        chk_all("done_strobes", 0, 0, 1, 4);
        bus_if.inc     = 1'b0;
        bus_if.load    = 1'b0;
        bus_if.tick_in = 1'b0;

        // Leaving DONE clears finish
        bus_if.mode = 2'b00;
        step();
        chk_all("leave_done", 0, 0, 0, 0);

        // IDLE ignores strobes
        bus_if.inc     = 1'b1;
        bus_if.tick_in = 1'b1;
        step();
        chk_all("idle_ignore", 0, 0, 0, 0);
        bus_if.inc     = 1'b0;
        bus_if.tick_in = 1'b0;

        // UP from 58
        bus_if.mode = 2'b01;
        step();
        bus_if.load       = 1'b1;
        bus_if.load_value = 6'd58;
        step();
        chk_all("load_58", 58, 0, 0, 1);
        bus_if.load = 1'b0;
        bus_if.mode = 2'b11;
        step();
        chk_all("enter_up", 58, 0, 0, 3);
        bus_if.tick_in = 1'b1;
        step();
        chk_all("up_t1", 59, 0, 0, 3);
        step();
        chk_all("up_wrap", 0, 1, 0, 3);
        bus_if.tick_in = 1'b0;
        step();
        chk_all("up_after", 0, 0, 0, 3);

        // Mode change 01->10 with tick_in and inc: old SET state handles it
        bus_if.mode = 2'b01;
        step();
        bus_if.load       = 1'b1;
        bus_if.load_value = 6'd5;
        step();
        chk_all("load_5", 5, 0, 0, 1);
        bus_if.load    = 1'b0;
        bus_if.mode    = 2'b10;
        bus_if.tick_in = 1'b1;
        bus_if.inc     = 1'b1;
        step();
        chk_all("mode_change", 6, 0, 0, 2);
        bus_if.inc = 1'b0;

        // enable low freezes everything
        bus_if.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("frozen", 6, 0, 0, 2);
        end
        bus_if.enable = 1'b1;
        step();
        chk_all("resume", 5, 0, 0, 2);

        // Count down to DONE: 5 more ticks reach 0, the sixth expires
        for (int i = 0; i < 6; i++) begin
            step();
        end
        chk_all("done_again", 0, 1, 1, 4);
        bus_if.tick_in = 1'b0;

        // Reset while in DONE with enable low
        bus_if.enable = 1'b0;
        reset = 1'b1;
        step();
        chk_all("reset_done", 0, 0, 0, 0);
        reset = 1'b0;
        step();
        chk_all("post_reset", 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_field_counter.md
# timer_field_counter

Parametrised modulo timer field for the VGA timer display chain. It generalises the fixed six-bit minutes counter to any width and modulo, with four modes: hold, set, count-down and count-up. In set mode it supports load, increment and decrement. It emits a one-cycle terminal-count strobe so fields can be cascaded (seconds → minutes → hours), and raises a sticky finish flag when a countdown expires. The display decoder reads `value` directly.

## Interface
- `WIDTH`, 6: bit width of `value` and `load_value`.
- `MODULO`, 60: field wraps at MODULO-1; legal range 2..2^WIDTH.
- `INIT`, 0: reset value of `value`; must be < MODULO.

- `clk_1Hz` in 1: clock; all state changes on its rising edge.
- `reset` in 1: reset, synchronous, active-high; clock clk_1Hz.
- `enable` in 1: high = block active; low = freeze state and value.
- `mode` in 2: 00 HOLD, 01 SET, 10 DOWN, 11 UP.
- `inc` in 1: single-cycle synchronous strobe, +1 in SET.
- `dec` in 1: single-cycle synchronous strobe, −1 in SET.
- `tick_in` in 1: count strobe from the lower field or timebase (e.g. seconds field terminal count).
- `load` in 1: load `load_value` in SET.
- `load_value` in WIDTH: preset value.
- `value` out WIDTH: current field value.
- `tc_out` out 1: one-cycle terminal-count/borrow strobe to the next field.
- `finish` out 1: sticky countdown-expired flag.
- `state` out 3: IDLE=0, SET=1, DOWN=2, UP=3, DONE=4; debug/status.

## Operation
- Reset, highest priority, overrides `enable`: `value`=INIT, `state`=IDLE, `finish`=0, `tc_out`=0.
- `enable`=0: `state`, `value` and `finish` hold; `tc_out`=0.
- Next-state logic, per edge with `enable`=1:
  - mode 00 → IDLE.
  - mode 01 → SET.
  - mode 11 → UP.
  - mode 10 → DOWN, except DONE stays DONE while mode=10.
  - A DOWN→DONE transition overrides mode.
- The action each edge is chosen by the current `state` register, not by `mode`. A mode change therefore takes effect one cycle later, and any strobe in the mode-change cycle is handled by the old state.
- IDLE: value holds, all strobes ignored.
- SET (priority load > inc/dec):
  - `load`: value ← `load_value`, or MODULO-1 if `load_value` ≥ MODULO (saturate).
  - `inc` only: value ← value+1; MODULO-1 wraps to 0.
  - `dec` only: value ← value−1; 0 wraps to MODULO-1.
  - `inc` and `dec` together: no change.
  - `tc_out` is never asserted in SET.
- DOWN, on `tick_in`:
  - value ≠ 0: value ← value−1.
  - value = 0: value stays 0, `finish` ← 1, `tc_out` ← 1 for one cycle, state ← DONE.
  - No `tick_in`: no change.
- UP, on `tick_in`:
  - value = MODULO-1: value ← 0, `tc_out` 1 for one cycle.
  - Otherwise value+1.
  - `finish` never set.
- DONE:
  - value held, `finish`=1, `tick_in`/`inc`/`dec`/`load` ignored.
  - Leaving DONE (mode ≠ 10) clears `finish` on the same edge.
- `inc`, `dec`, `load` are ignored outside SET; `tick_in` is ignored outside DOWN/UP.
- Arithmetic is WIDTH-bit. Comparisons use MODULO-1 as a WIDTH-bit constant. No value ≥ MODULO is ever reachable.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- `value` updates on the edge that samples the strobe (latency 1 cycle).
- `tc_out` is high for exactly the cycle following that edge, aligned with the wrapped/zero `value`.
- `finish` and state DONE assert on the same edge as the final `tc_out`.
- Back-to-back `tick_in` on consecutive cycles: each one counted.
- Reset asserted mid-count or in DONE: all outputs take their reset values after that edge, regardless of other inputs.

## Test plan
- Reset with INIT=0, then mode=01 and 61 `inc` strobes → `value` steps 0..59, then 0, then 1; `tc_out` never high.
- SET, `load` with `load_value`=63 → `value`=59. Next, `dec` 60 times → ends at 59 after wrapping through 0. Simultaneous `inc`+`dec` → unchanged.
- Load 2, mode=10, three `tick_in` → `value` 1, 0, 0. The third tick gives `tc_out`=1 for one cycle, `finish`=1, `state`=4. Further ticks give no change. mode=00 → `finish`=0, `state`=0.
- UP from 58, two `tick_in` → 59, then 0 with a one-cycle `tc_out`; `finish` stays 0.
- Mode change 01→10 in the same cycle as `tick_in` → tick ignored (the SET action applies). `enable`=0 for 3 ticks → `value` frozen, `tc_out`=0.
- `reset` pulsed while in DONE with `enable`=0 → `value`=0, `finish`=0, `state`=0 on the next edge.
